// File: rtl/segre_mem_responder.sv
// Fixed-latency cache-line memory responder for the Segre unified memory port.
// Define SEGRE_MEM_PROTOCOL_CHECK_EN to build the sticky protocol_err_o checker.
package segre_mem_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD,
        MEM_DWORD
    } memop_data_type_e;
endpackage

module segre_mem_responder
    import segre_mem_pkg::*;
#(
    parameter int ADDR_SIZE             = 32,
    parameter int CACHE_LINE_SIZE_BYTES = 16,
    parameter int MEM_DEPTH_LINES       = 1024,
    parameter int LATENCY               = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [ADDR_SIZE-1:0]                  addr_i,
    input  logic                                  mem_rd_i,
    input  logic                                  mem_wr_i,
    input  memop_data_type_e                      mem_data_type_i,
    input  logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] mem_wr_data_i,
    output logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] mem_rd_data_o,
    output logic                                  mem_ready_o,
    output logic                                  busy_o,
    output logic                                  protocol_err_o
);
    localparam int OFF_W = $clog2(CACHE_LINE_SIZE_BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH_LINES);

    typedef logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] line_t;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e           state, next_state;
    logic [7:0]       cnt, next_cnt;
    logic [IDX_W-1:0] idx;
    logic             is_wr;
    line_t            wdata;
    memop_data_type_e dtype;
    line_t            mem [MEM_DEPTH_LINES];

    logic accept, commit, load_rd, abort, req_held;

    assign req_held = is_wr ? mem_wr_i : mem_rd_i;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        load_rd    = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_rd_i || mem_wr_i) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                    next_cnt   = 8'(LATENCY - 1);
                end
            end
            BUSY: begin
                // Initiator dropped its request: the arbiter moved on
                if (!req_held) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (cnt != 8'd0) begin
                    next_cnt = cnt - 8'd1;
                end else begin
                    next_state = RESP;
                    commit     = is_wr;
                    load_rd    = !is_wr;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            idx           <= '0;
            is_wr         <= 1'b0;
            wdata         <= '0;
            dtype         <= MEM_BYTE;
            mem_rd_data_o <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (accept) begin
                idx   <= addr_i[OFF_W +: IDX_W];
                is_wr <= mem_wr_i;
                wdata <= mem_wr_data_i;
                dtype <= mem_data_type_i;
            end
            if (load_rd) mem_rd_data_o <= mem[idx];
        end
    end

    // Backing store is deliberately unreset so contents survive rst_i
    always_ff @(posedge clk_i) begin
        if (commit) mem[idx] <= wdata;
    end

    assign mem_ready_o = (state == RESP);
    assign busy_o      = (state != IDLE);

`ifdef SEGRE_MEM_PROTOCOL_CHECK_EN
    logic [ADDR_SIZE-1:0] addr_q;
    logic                 err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            err    <= 1'b0;
        end else begin
            if (accept) addr_q <= addr_i;
            if ((accept && mem_rd_i && mem_wr_i) || abort ||
                (state == BUSY && req_held && addr_i != addr_q))
                err <= 1'b1;
        end
    end

    assign protocol_err_o = err;
`else
    assign protocol_err_o = 1'b0;
`endif

    // Offset/alias address bits and the access type carry no storage meaning
    logic unused_ok;
    assign unused_ok = ^{addr_i, dtype, abort};
endmodule

// File: tb/tb_segre_mem_responder.sv
// Directed bench for segre_mem_responder: LATENCY=4 instance plus a LATENCY=1 instance.
// Expected values are hand-derived constants; protocol_err_o expectation follows the build macro.
module tb_segre_mem_responder;
    import segre_mem_pkg::*;

    localparam int L = 4;
    typedef logic [15:0][7:0] line_t;

`ifdef SEGRE_MEM_PROTOCOL_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    localparam line_t LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam line_t LINE_B = 128'hDEADBEEF_01020304_A5A5A5A5_0F1E2D3C;
    localparam line_t LINE_C = 128'hCAFEF00D_11111111_22222222_33333333;
    localparam line_t LINE_D = 128'h98765432_10FEDCBA_55AA55AA_77777777;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      addr, addr1;
    logic             rd, wr, rd1, wr1;
    memop_data_type_e dt;
    line_t            wdata, rdata, wdata1, rdata1;
    logic             ready, busy, err, ready1, busy1, err1;

    always #5 clk = ~clk;

    segre_mem_responder #(.LATENCY(L)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr),
        .mem_rd_i(rd), .mem_wr_i(wr), .mem_data_type_i(dt),
        .mem_wr_data_i(wdata), .mem_rd_data_o(rdata),
        .mem_ready_o(ready), .busy_o(busy), .protocol_err_o(err)
    );

    segre_mem_responder #(.LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr1),
        .mem_rd_i(rd1), .mem_wr_i(wr1), .mem_data_type_i(dt),
        .mem_wr_data_i(wdata1), .mem_rd_data_o(rdata1),
        .mem_ready_o(ready1), .busy_o(busy1), .protocol_err_o(err1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, hold until ready, then let RESP retire
    task automatic xfer(input logic w, input logic [31:0] a, input line_t d,
                        output int lat, output line_t q);
        addr  = a;
        wdata = d;
        wr    = w;
        rd    = !w;
        lat   = 0;
        for (int i = 0; i < 20 && !ready; i++) begin
            tick();
            lat++;
        end
        if (!ready) lat = -1;
        q  = rdata;
        rd = 1'b0;
        wr = 1'b0;
        tick();
    endtask

    int    lat, n;
    line_t q;
    logic  saw;

    initial begin
        dt = MEM_WORD;
        {rd, wr, rd1, wr1} = '0;
        addr = '0; addr1 = '0; wdata = '0; wdata1 = '0;
        #12;
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_ready1", ready1, 0);
        rst = 1'b0;
        tick();

        xfer(1'b1, 32'h40, LINE_A, lat, q);
        chk("wr_lat", lat, L + 1);
        chk("wr_idle", busy, 0);
        xfer(1'b0, 32'h40, '0, lat, q);
        chk("rd_lat", lat, L + 1);
        chk("rd_data", q, LINE_A);
        chk("rd_hold", rdata, LINE_A);

        xfer(1'b1, 32'h4040, LINE_B, lat, q);
        xfer(1'b0, 32'h004C, '0, lat, q);
        chk("alias_data", q, LINE_B);
        xfer(1'b1, 32'h80, LINE_C, lat, q);
        chk("no_err", err, 0);

        addr = 32'h40;
        rd   = 1'b1;
        n    = 0;
        while (!ready && n < 20) begin tick(); n++; end
        chk("b2b_first", rdata, LINE_B);
        addr = 32'h80;
        tick();
        chk("b2b_gap_idle", busy, 0);
        n = 1;
        while (!ready && n < 20) begin tick(); n++; end
        chk("b2b_period", n, L + 2);
        chk("b2b_data", rdata, LINE_C);
        rd = 1'b0;
        tick();

        addr = 32'h80;
        rd   = 1'b1;
        tick();
        chk("abort_busy", busy, 1);
        saw = ready;
        tick(); saw |= ready;
        tick(); saw |= ready;
        rd = 1'b0;
        tick(); saw |= ready;
        chk("abort_idle", busy, 0);
        tick(); saw |= ready;
        chk("abort_noready", saw, 0);
        chk("abort_err", err, CHK);

        xfer(1'b1, 32'h100, LINE_A, lat, q);
        addr  = 32'h100;
        wdata = LINE_D;
        wr    = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_ready", ready, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_rdata", rdata, 0);
        chk("mrst_err", err, 0);
        wr = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        xfer(1'b0, 32'h100, '0, lat, q);
        chk("mrst_old", q, LINE_A);

        addr1  = 32'h20;
        wdata1 = LINE_D;
        rd1    = 1'b1;
        wr1    = 1'b1;
        tick();
        chk("l1_busy", busy1, 1);
        chk("l1_noready", ready1, 0);
        tick();
        chk("l1_ready", ready1, 1);
        rd1 = 1'b0;
        wr1 = 1'b0;
        tick();
        chk("l1_err", err1, CHK);
        rd1 = 1'b1;
        tick();
        tick();
        chk("l1_rd_ready", ready1, 1);
        chk("l1_rd_data", rdata1, LINE_D);
        rd1 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
